// File: rtl/fpnew_wb_buffer.sv
// -----------------------------------------------------------------------------
// fpnew_wb_buffer
//
// In-order writeback queue between the FPU output port and the register-file
// writeback port. Result/status/tag beats are accepted with a valid/ready
// handshake, stored in a small circular FIFO and presented head-first to the
// writeback port. The IEEE status flags of every committed (popped) entry are
// OR-accumulated into sticky fflags for the CSR unit.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               synchronous flush, drops all queued entries and the
//                         incoming beat
//   fpu_result_i/status_i/tag_i/valid_i, fpu_ready_o
//                         upstream (FPU) beat and handshake
//   wb_result_o/status_o/tag_o/valid_o, wb_ready_i
//                         downstream (writeback) head entry and handshake
//   fflags_clr_i, fflags_o
//                         sticky status flags and their clear
//   usage_o, busy_o       occupancy and non-empty indication
// -----------------------------------------------------------------------------
module fpnew_wb_buffer #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [Width-1:0]           fpu_result_i,
    input  logic [4:0]                 fpu_status_i,
    input  TagType                     fpu_tag_i,
    input  logic                       fpu_valid_i,
    output logic                       fpu_ready_o,
    output logic [Width-1:0]           wb_result_o,
    output logic [4:0]                 wb_status_o,
    output TagType                     wb_tag_o,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    input  logic                       fflags_clr_i,
    output logic [4:0]                 fflags_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    // Entry storage; intentionally not reset, only the pointers/count are.
    logic [Width-1:0] r_result_mem [Depth];
    logic [4:0]       r_status_mem [Depth];
    TagType           r_tag_mem    [Depth];

    logic [AddrW-1:0] r_wr_ptr;
    logic [AddrW-1:0] r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [4:0]       r_fflags;

    logic [AddrW-1:0] w_wr_ptr_next;
    logic [AddrW-1:0] w_rd_ptr_next;
    logic [CntW-1:0]  w_count_next;
    logic [4:0]       w_fflags_next;
    logic             w_push;
    logic             w_pop;
    logic [Depth-1:0] w_wr_en;

    // Ready depends only on registered occupancy (and reset), so there is no
    // combinational path from wb_ready_i back to the FPU. A slot freed by a
    // pop therefore becomes visible upstream one cycle later.
    assign fpu_ready_o = (r_count != FullCnt) & ~rst_i;
    assign wb_valid_o  = (r_count != '0);
    assign busy_o      = wb_valid_o;
    assign usage_o     = r_count;
    assign fflags_o    = r_fflags;

    // Flush wins over both handshakes.
    assign w_push = fpu_valid_i & fpu_ready_o & ~flush_i;
    assign w_pop  = wb_valid_o & wb_ready_i & ~flush_i;

    // Head entry, forced to zero while the queue is empty.
    assign wb_result_o = wb_valid_o ? r_result_mem[r_rd_ptr] : '0;
    assign wb_status_o = wb_valid_o ? r_status_mem[r_rd_ptr] : '0;
    assign wb_tag_o    = wb_valid_o ? r_tag_mem[r_rd_ptr]    : '0;

    // Per-entry write enables decoded from the write pointer.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_wr_en
        assign w_wr_en[gi] = w_push & (r_wr_ptr == AddrW'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < Depth; i++) begin
            if (w_wr_en[i]) begin
                r_result_mem[i] <= fpu_result_i;
                r_status_mem[i] <= fpu_status_i;
                r_tag_mem[i]    <= fpu_tag_i;
            end
        end
    end

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (flush_i) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            // Depth is a power of two, so natural pointer overflow is the wrap.
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + AddrW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + AddrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CntW'(1);
                2'b01:   w_count_next = r_count - CntW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Clear and pop in the same cycle leave exactly the popped status.
    // Flushed entries never pop, so they never reach the flags.
    always_comb begin
        w_fflags_next = fflags_clr_i ? 5'b0 : r_fflags;
        if (w_pop) begin
            w_fflags_next = w_fflags_next | wb_status_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fflags <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_fflags <= w_fflags_next;
        end
    end

endmodule

// File: tb/tb_fpnew_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_fpnew_wb_buffer
//
// Self-checking bench for fpnew_wb_buffer (Width=64, Depth=4, 8-bit tag).
// A cycle table covers the single-beat latency case and the full/back-pressure
// case; hand-written sequences cover streaming, flush, sticky-flag clear and
// asynchronous reset. Expected outputs are checked on the falling edge, inputs
// for the next rising edge are driven right after.
// -----------------------------------------------------------------------------
module tb_fpnew_wb_buffer;

    typedef logic [7:0] tag_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [63:0] fpu_result;
    logic [4:0]  fpu_status;
    tag_t        fpu_tag;
    logic        fpu_valid;
    logic        fpu_ready;
    logic [63:0] wb_result;
    logic [4:0]  wb_status;
    tag_t        wb_tag;
    logic        wb_valid;
    logic        wb_ready;
    logic        fflags_clr;
    logic [4:0]  fflags;
    logic [2:0]  usage;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fpnew_wb_buffer #(
        .Width   (64),
        .Depth   (4),
        .TagType (tag_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .fpu_result_i (fpu_result),
        .fpu_status_i (fpu_status),
        .fpu_tag_i    (fpu_tag),
        .fpu_valid_i  (fpu_valid),
        .fpu_ready_o  (fpu_ready),
        .wb_result_o  (wb_result),
        .wb_status_o  (wb_status),
        .wb_tag_o     (wb_tag),
        .wb_valid_o   (wb_valid),
        .wb_ready_i   (wb_ready),
        .fflags_clr_i (fflags_clr),
        .fflags_o     (fflags),
        .usage_o      (usage),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [63:0] res;
        logic [4:0]  st;
        tag_t        tag;
        logic        wbr;
        logic        e_valid;
        logic [63:0] e_res;
        logic [4:0]  e_st;
        tag_t        e_tag;
        logic        e_ready;
        logic [2:0]  e_usage;
        logic [4:0]  e_ff;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic fv, input logic [63:0] res, input logic [4:0] st,
                                input tag_t tag, input logic wbr,
                                input logic e_valid, input logic [63:0] e_res, input logic [4:0] e_st,
                                input tag_t e_tag, input logic e_ready, input logic [2:0] e_usage,
                                input logic [4:0] e_ff);
        vec_t v;
        v.fv = fv; v.res = res; v.st = st; v.tag = tag; v.wbr = wbr;
        v.e_valid = e_valid; v.e_res = e_res; v.e_st = e_st; v.e_tag = e_tag;
        v.e_ready = e_ready; v.e_usage = e_usage; v.e_ff = e_ff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [63:0] res, input logic [4:0] st,
                         input tag_t tag, input logic wbr, input logic clr);
        flush      = fl;
        fpu_valid  = fv;
        fpu_result = res;
        fpu_status = st;
        fpu_tag    = tag;
        wb_ready   = wbr;
        fflags_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 5'b0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single beat, then 5 beats into a 4-deep queue with back-pressure.
        vecs[0]  = mk(1, 64'h3FF0000000000000, 5'b00001, 8'd1, 1,  0, 64'h0, 5'b0, 8'd0, 1, 3'd0, 5'b00000);
        vecs[1]  = mk(0, 64'h0, 5'b0, 8'd0, 1,  1, 64'h3FF0000000000000, 5'b00001, 8'd1, 1, 3'd1, 5'b00000);
        vecs[2]  = mk(0, 64'h0, 5'b0, 8'd0, 0,  0, 64'h0, 5'b0, 8'd0, 1, 3'd0, 5'b00001);
        vecs[3]  = mk(1, 64'h100, 5'b0, 8'd10, 0,  0, 64'h0, 5'b0, 8'd0, 1, 3'd0, 5'b00001);
        vecs[4]  = mk(1, 64'h101, 5'b0, 8'd11, 0,  1, 64'h100, 5'b0, 8'd10, 1, 3'd1, 5'b00001);
        vecs[5]  = mk(1, 64'h102, 5'b0, 8'd12, 0,  1, 64'h100, 5'b0, 8'd10, 1, 3'd2, 5'b00001);
        vecs[6]  = mk(1, 64'h103, 5'b0, 8'd13, 0,  1, 64'h100, 5'b0, 8'd10, 1, 3'd3, 5'b00001);
        vecs[7]  = mk(1, 64'h104, 5'b0, 8'd14, 0,  1, 64'h100, 5'b0, 8'd10, 0, 3'd4, 5'b00001);
        vecs[8]  = mk(1, 64'h104, 5'b0, 8'd14, 1,  1, 64'h100, 5'b0, 8'd10, 0, 3'd4, 5'b00001);
        vecs[9]  = mk(1, 64'h104, 5'b0, 8'd14, 0,  1, 64'h101, 5'b0, 8'd11, 1, 3'd3, 5'b00001);
        vecs[10] = mk(0, 64'h0, 5'b0, 8'd0, 1,  1, 64'h101, 5'b0, 8'd11, 0, 3'd4, 5'b00001);
        vecs[11] = mk(0, 64'h0, 5'b0, 8'd0, 1,  1, 64'h102, 5'b0, 8'd12, 1, 3'd3, 5'b00001);
        vecs[12] = mk(0, 64'h0, 5'b0, 8'd0, 1,  1, 64'h103, 5'b0, 8'd13, 1, 3'd2, 5'b00001);
        vecs[13] = mk(0, 64'h0, 5'b0, 8'd0, 1,  1, 64'h104, 5'b0, 8'd14, 1, 3'd1, 5'b00001);
        vecs[14] = mk(0, 64'h0, 5'b0, 8'd0, 0,  0, 64'h0, 5'b0, 8'd0, 1, 3'd0, 5'b00001);

        // Reset
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, fpu_ready}, 64'd0);
        chk("reset_valid", {63'd0, wb_valid}, 64'd0);
        chk("reset_usage", {61'd0, usage}, 64'd0);
        chk("reset_fflags", {59'd0, fflags}, 64'd0);
        chk("reset_result", wb_result, 64'd0);
        rst = 1'b0;

        // Table-driven section
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {63'd0, wb_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_result", i), wb_result, vecs[i].e_res);
            chk($sformatf("v%0d_status", i), {59'd0, wb_status}, {59'd0, vecs[i].e_st});
            chk($sformatf("v%0d_tag", i), {56'd0, wb_tag}, {56'd0, vecs[i].e_tag});
            chk($sformatf("v%0d_ready", i), {63'd0, fpu_ready}, {63'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_usage", i), {61'd0, usage}, {61'd0, vecs[i].e_usage});
            chk($sformatf("v%0d_fflags", i), {59'd0, fflags}, {59'd0, vecs[i].e_ff});
            drive(1'b0, vecs[i].fv, vecs[i].res, vecs[i].st, vecs[i].tag, vecs[i].wbr, 1'b0);
        end

        // Streaming: push and pop every cycle, tags 0..19 in order, usage 1.
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("stream%0d_valid", k), {63'd0, wb_valid}, 64'd1);
                chk($sformatf("stream%0d_tag", k), {56'd0, wb_tag}, 64'(k - 1));
                chk($sformatf("stream%0d_result", k), wb_result, 64'(k - 1));
                chk($sformatf("stream%0d_usage", k), {61'd0, usage}, 64'd1);
            end
            drive(1'b0, (k < 20), 64'(k), 5'b0, tag_t'(k), 1'b1, 1'b0);
        end
        @(negedge clk);
        chk("stream_end_usage", {61'd0, usage}, 64'd0);
        chk("stream_end_valid", {63'd0, wb_valid}, 64'd0);
        idle();

        // Flush with 3 entries queued (NV, OF, NX) and an incoming DZ beat.
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h300, 5'b10000, 8'd30, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h301, 5'b00100, 8'd31, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h302, 5'b00001, 8'd32, 1'b0, 1'b0);
        @(negedge clk);
        chk("preflush_usage", {61'd0, usage}, 64'd3);
        chk("preflush_head_status", {59'd0, wb_status}, 64'b10000);
        drive(1'b1, 1'b1, 64'h303, 5'b01000, 8'd33, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_usage", {61'd0, usage}, 64'd0);
        chk("flush_valid", {63'd0, wb_valid}, 64'd0);
        chk("flush_fflags", {59'd0, fflags}, 64'b00001);
        chk("flush_ready", {63'd0, fpu_ready}, 64'd1);
        idle();
        @(negedge clk);
        chk("postflush_valid", {63'd0, wb_valid}, 64'd0);
        chk("postflush_fflags", {59'd0, fflags}, 64'b00001);

        // Sticky flags: clear together with popping NV gives NV only, then
        // clear together with popping DZ gives DZ only.
        drive(1'b0, 1'b1, 64'h400, 5'b10000, 8'd40, 1'b0, 1'b0);
        @(negedge clk);
        chk("ff_head_tag40", {56'd0, wb_tag}, 64'd40);
        drive(1'b0, 1'b1, 64'h401, 5'b01000, 8'd41, 1'b1, 1'b1);
        @(negedge clk);
        chk("ff_clr_pop_nv", {59'd0, fflags}, 64'b10000);
        chk("ff_head_tag41", {56'd0, wb_tag}, 64'd41);
        chk("ff_usage1", {61'd0, usage}, 64'd1);
        drive(1'b0, 1'b0, 64'h0, 5'b0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk("ff_clr_pop_dz", {59'd0, fflags}, 64'b01000);
        chk("ff_usage0", {61'd0, usage}, 64'd0);

        // Async reset with 2 entries queued and non-zero flags.
        drive(1'b0, 1'b1, 64'h500, 5'b00010, 8'd50, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 64'h501, 5'b00100, 8'd51, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        chk("prerst_usage", {61'd0, usage}, 64'd2);
        chk("prerst_fflags", {59'd0, fflags}, 64'b01000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, wb_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_usage", {61'd0, usage}, 64'd0);
        chk("arst_fflags", {59'd0, fflags}, 64'd0);
        chk("arst_ready", {63'd0, fpu_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("arst_ready_held", {63'd0, fpu_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {63'd0, fpu_ready}, 64'd1);
        chk("rst_release_valid", {63'd0, wb_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpnew_wb_buffer.md
Name: fpnew_wb_buffer

Overview:
- Writeback buffer directly downstream of the FPU top-level output port.
- Accepts result/status/tag beats via valid/ready and queues them in an in-order FIFO.
- Presents the queued beats to the register-file writeback port.
- Accumulates the IEEE status flags of committed results into sticky fflags for the CSR unit.

Parameters:
- Width, 64, result width in bits; equals the FPU Width.
- Depth, 4, number of FIFO entries; power of two, at least 2.
- TagType, logic, type of the operation tag carried alongside each result.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush; discards all queued entries.
- fpu_result_i  in  Width  result from the FPU.
- fpu_status_i  in  5  status {NV,DZ,OF,UF,NX} from the FPU.
- fpu_tag_i  in  TagType  tag from the FPU.
- fpu_valid_i  in  1  FPU output valid.
- fpu_ready_o  out  1  buffer can accept; drives the FPU out_ready.
- wb_result_o  out  Width  head-entry result.
- wb_status_o  out  5  head-entry status.
- wb_tag_o  out  TagType  head-entry tag.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback port accepts the head entry.
- fflags_clr_i  in  1  clears the sticky flags (CSR write).
- fflags_o  out  5  sticky OR of the status of all committed entries.
- usage_o  out  $clog2(Depth+1)  current entry count.
- busy_o  out  1  one or more entries queued.

Behaviour:
- Reset (rst_i high, asynchronous):
  - Pointers, count, fflags_o and usage_o go to 0.
  - wb_valid_o = 0, busy_o = 0.
  - wb_result_o, wb_status_o and wb_tag_o are 0.
  - fpu_ready_o is forced to 0 while rst_i is high.
  - Entry storage is not reset.
- Push: fpu_valid_i & fpu_ready_o & !flush_i. Writes the entry at the write pointer; write pointer += 1, wrapping mod Depth.
- Pop: wb_valid_o & wb_ready_i & !flush_i. Read pointer += 1, wrapping mod Depth.
- Signal definitions:
  - fpu_ready_o = (count != Depth) & !rst_i. Registered-state only; no combinational path from wb_ready_i.
  - wb_valid_o = (count != 0).
  - wb_* data = head entry when wb_valid_o is high, else all zero.
  - busy_o = wb_valid_o. usage_o = count.
- No fall-through: a beat pushed in cycle N is visible at wb_* in cycle N+1 at the earliest. Minimum latency is 1 cycle.
- Full throughput: push and pop in the same cycle leave count unchanged, and both pointers advance.
- Full: fpu_ready_o = 0, so no push occurs even if a pop happens that cycle. Ready rises the cycle after the pop.
- Empty: no pop can occur; wb_valid_o = 0.
- AXI-style handshake stability:
  - Once wb_valid_o is high, it and wb_* stay stable until the pop or a flush.
  - The upstream FPU holds its beat stable while fpu_ready_o is low.
- Flush (flush_i high), takes priority over push and pop:
  - Next cycle: count = 0 and pointers = 0.
  - The incoming beat is dropped.
  - Flushed entries do not contribute to fflags.
  - fflags_o is unaffected by flush except through fflags_clr_i.
- Sticky flags: fflags_next = (fflags_clr_i ? 0 : fflags_o) | (pop ? wb_status_o : 0).
  - A clear and a pop in the same cycle leave exactly the popped status.
  - Flags are updated one cycle after the pop.
- Count arithmetic: push only → +1; pop only → −1; both or neither → unchanged. Count never exceeds Depth and never goes below 0.
- Reset asserted mid-operation discards all entries and flags immediately (asynchronous).

Test Plan:
- Reset, then push result 0x3FF0000000000000, status 5'b00001, tag 1, with wb_ready_i=1:
  - wb_valid_o rises one cycle later with that data.
  - It is popped that cycle.
  - fflags_o = 5'b00001 in the following cycle.
- wb_ready_i=0, push 5 beats back-to-back with Depth=4:
  - First 4 accepted; fpu_ready_o low after the 4th; usage_o = 4.
  - The 5th beat is held upstream.
  - Raising wb_ready_i for 1 cycle pops entry 0; fpu_ready_o rises the next cycle.
- Continuous fpu_valid_i and wb_ready_i for 20 cycles with incrementing tags:
  - One pop per cycle after the first.
  - Tags emerge in order 0..19; usage_o stays at 1.
  - Pointers wrap correctly.
- Queue 3 entries with status NV, OF, NX, then assert flush_i with fpu_valid_i=1:
  - Next cycle usage_o = 0 and wb_valid_o = 0.
  - fflags_o unchanged; the flushed beat never appears.
- fflags_o = 5'b10000, then pop an entry with status DZ in the same cycle as fflags_clr_i:
  - fflags_o = 5'b01000 next cycle.
- Assert rst_i asynchronously between edges with 2 entries queued:
  - wb_valid_o, busy_o, usage_o and fflags_o drop to 0 before the next edge.
  - fpu_ready_o stays 0 until rst_i is released.
